// File: rtl/dmem_stage.sv
// Data-memory stage for the SEQ Y86-64 datapath: icode-decoded read/write with a
// start/done handshake, LAT wait cycles, range checking and a sticky error flag.
module dmem_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valA,
    input  logic [ADDR_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] memdata,
    output logic              dmem_err,
    output logic [1:0]        dbg_state
);
    // Handshake: start is accepted only in IDLE (busy=0); done pulses for one cycle
    // in RESP and busy stays high from the cycle after accept until done is seen.

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_C = 4'(LAT);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic wr_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic in_wr, in_rd;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;

    logic acc_wr, acc_rd, acc_en, acc_inr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic accept;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        in_wr    = 1'b0;
        in_rd    = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        case (icode)
            4'h4, 4'hA: begin in_wr = 1'b1; in_addr = valE; in_wdata = DATA_W'(valA); end
            4'h8:       begin in_wr = 1'b1; in_addr = valE; in_wdata = valP; end
            4'h5:       begin in_rd = 1'b1; in_addr = valE; end
            4'h9, 4'hB: begin in_rd = 1'b1; in_addr = valA; end
            default: ;
        endcase
    end

    // With LAT=0 the access edge is the accept edge, so use the live operands there.
    always_comb begin
        if (state_q == IDLE) begin
            acc_wr    = in_wr;
            acc_rd    = in_rd;
            acc_addr  = in_addr;
            acc_wdata = in_wdata;
        end else begin
            acc_wr    = wr_q;
            acc_rd    = rd_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign accept  = (state_q == IDLE) && start;
    assign acc_inr = acc_addr < DEPTH_A;
    assign acc_idx = acc_addr[IDX_W-1:0];
    assign acc_en  = (state_d == RESP) && (state_q != RESP) && (acc_wr || acc_rd);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_wr || in_rd) begin
                        cnt_d   = LAT_C;
                        state_d = (LAT_C != 4'd0) ? WAIT : RESP;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    // Array is not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && acc_en && acc_wr && acc_inr) mem[acc_idx] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valM     <= '0;
            memdata  <= '0;
            dmem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= in_wr;
                rd_q    <= in_rd;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
            end
            if (acc_en) begin
                if (!acc_inr) begin
                    dmem_err <= 1'b1;
                    memdata  <= '0;
                    if (acc_rd) valM <= '0;
                end else if (acc_wr) begin
                    memdata <= acc_wdata;
                end else begin
                    valM    <= mem[acc_idx];
                    memdata <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: two instances (LAT=1 and LAT=3) share the request inputs;
// a reference model predicts each response and the exact done cycle.
module tb_dmem_stage;
    localparam int W = 129;

    logic clk = 1'b0;
    logic rst1_n, rst3_n, start;
    logic [3:0] icode;
    logic [63:0] valA, valE, valP;
    logic busy1, done1, err1, busy3, done3, err3;
    logic [63:0] valm1, memd1, valm3, memd3;
    logic [1:0] st1, st3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q0[$], exp_q1[$];
    int due_q0[$], due_q1[$];

    logic [63:0] mm [2][1024];
    logic [63:0] lv [2];
    logic [63:0] lm [2];
    logic        le [2];

    dmem_stage #(.DATA_W(64), .ADDR_W(64), .DEPTH(1024), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start), .icode(icode), .valA(valA),
        .valE(valE), .valP(valP), .busy(busy1), .done(done1), .valM(valm1),
        .memdata(memd1), .dmem_err(err1), .dbg_state(st1)
    );

    dmem_stage #(.DATA_W(64), .ADDR_W(64), .DEPTH(1024), .LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .start(start), .icode(icode), .valA(valA),
        .valE(valE), .valP(valP), .busy(busy3), .done(done3), .valM(valm3),
        .memdata(memd3), .dmem_err(err3), .dbg_state(st3)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'(i * 3);
    endfunction

    function automatic bit is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // reference model: returns {dmem_err, memdata, valM} after the request
    function automatic logic [W-1:0] model(input int id, input logic [3:0] ic,
                                           input logic [63:0] a, input logic [63:0] e,
                                           input logic [63:0] p);
        logic wr, rd;
        logic [63:0] ad, wd;
        wr = 1'b0; rd = 1'b0; ad = '0; wd = '0;
        case (ic)
            4'h4, 4'hA: begin wr = 1'b1; ad = e; wd = a; end
            4'h8:       begin wr = 1'b1; ad = e; wd = p; end
            4'h5:       begin rd = 1'b1; ad = e; end
            4'h9, 4'hB: begin rd = 1'b1; ad = a; end
            default: ;
        endcase
        if (wr || rd) begin
            if (ad >= 64'd1024) begin
                le[id] = 1'b1;
                lm[id] = '0;
                if (rd) lv[id] = '0;
            end else if (wr) begin
                mm[id][ad[9:0]] = wd;
                lm[id] = wd;
            end else begin
                lv[id] = mm[id][ad[9:0]];
                lm[id] = lv[id];
            end
        end
        return {le[id], lm[id], lv[id]};
    endfunction

    // scoreboard
    task automatic push(input int id, input logic [W-1:0] v, input int due);
        if (id == 0) begin exp_q0.push_back(v); due_q0.push_back(due); end
        else begin exp_q1.push_back(v); due_q1.push_back(due); end
    endtask

    task automatic check_resp(input int id, input logic [W-1:0] obs, input logic b);
        logic [W-1:0] e;
        int d, sz;
        sz = (id == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        assert (sz != 0) else begin
            errors++;
            $error("FAIL unexpected_done dut%0d: observed done with %0d pending expected >0", id, sz);
        end
        if (sz != 0) begin
            if (id == 0) begin e = exp_q0.pop_front(); d = due_q0.pop_front(); end
            else begin e = exp_q1.pop_front(); d = due_q1.pop_front(); end
            chk($sformatf("resp_dut%0d", id), obs, e);
            chk($sformatf("latency_dut%0d", id), W'(cyc), W'(d));
            chk($sformatf("busy_at_done_dut%0d", id), W'(b), W'(1));
        end
    endtask

    always @(negedge clk) begin
        if (rst1_n && done1) check_resp(0, {err1, memd1, valm1}, busy1);
        if (rst3_n && done3) check_resp(1, {err3, memd3, valm3}, busy3);
    end

    // driver tasks
    task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input bit skip3);
        int n;
        @(posedge clk); #1;
        icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
        n = cyc;
        push(0, model(0, ic, a, e, p), n + 1 + (is_mem(ic) ? 1 : 0));
        if (!skip3) push(1, model(1, ic, a, e, p), n + 1 + (is_mem(ic) ? 3 : 0));
        @(posedge clk); #1;
        start = 1'b0;
        icode = 4'($urandom_range(0, 15));
        valA = {$urandom, $urandom};
        valE = {$urandom, $urandom};
        valP = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", W'(exp_q0.size() + exp_q1.size()), '0);
        exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    endtask

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0; start = 1'b0;
        icode = 4'h0; valA = '0; valE = '0; valP = '0;
        for (int i = 0; i < 2; i++) begin lv[i] = '0; lm[i] = '0; le[i] = 1'b0; end

        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1; rst3_n = 1'b1;
        chk("rst_out_dut0", W'({busy1, done1, err1, memd1, valm1, st1}), '0);
        chk("rst_out_dut1", W'({busy3, done3, err3, memd3, valm3, st3}), '0);
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", W'({busy1, busy3, done1, done3}), '0);
        end

        // known contents everywhere (array is not reset)
        for (int i = 0; i < 1024; i++) begin
            issue(4'h4, pat(i), 64'(i), 64'h0, 1'b0);
            wait_done();
        end

        // write then read back
        issue(4'h4, 64'hDEAD_BEEF, 64'd16, 64'h0, 1'b0); wait_done();
        issue(4'h5, 64'h0, 64'd16, 64'h0, 1'b0);         wait_done();

        // stack ops
        issue(4'h8, 64'h0, 64'd1000, 64'h40, 1'b0); wait_done();
        issue(4'h9, 64'd1000, 64'h0, 64'h0, 1'b0);  wait_done();
        issue(4'hA, 64'd7, 64'd999, 64'h0, 1'b0);   wait_done();
        issue(4'hB, 64'd999, 64'h0, 64'h0, 1'b0);   wait_done();

        // range errors: boundary, high bits beyond the index width, bad read
        issue(4'h4, 64'd5, 64'd1024, 64'h0, 1'b0);                  wait_done();
        issue(4'h5, 64'h0, 64'd0, 64'h0, 1'b0);                     wait_done();
        issue(4'h4, 64'h77, 64'h0000_0001_0000_0010, 64'h0, 1'b0);  wait_done();
        issue(4'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h99, 1'b0);  wait_done();
        issue(4'hB, 64'd2000, 64'h0, 64'h0, 1'b0);                  wait_done();
        issue(4'h5, 64'h0, 64'd1023, 64'h0, 1'b0);                  wait_done();

        // probe for corruption
        for (int i = 0; i < 1024; i++) begin
            issue(4'h5, 64'h0, 64'(i), 64'h0, 1'b0);
            wait_done();
        end

        // start while busy is ignored
        issue(4'h4, 64'h1234, 64'd20, 64'h0, 1'b0);
        chk("busy_after_accept", W'({busy1, busy3}), W'(2'b11));
        start = 1'b1; icode = 4'h5; valE = 64'd21;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (6) @(posedge clk);

        // non-memory icode
        issue(4'h6, 64'h5555, 64'd3, 64'h0, 1'b0); wait_done();
        issue(4'h5, 64'h0, 64'd20, 64'h0, 1'b0);   wait_done();
        issue(4'h0, 64'h0, 64'd20, 64'h0, 1'b0);   wait_done();

        // reset of the LAT=3 instance on its 2nd wait cycle
        issue(4'h4, 64'd9, 64'd8, 64'h0, 1'b1);
        @(posedge clk); #1 rst3_n = 1'b0;
        @(posedge clk); #1 rst3_n = 1'b1;
        lv[1] = '0; lm[1] = '0; le[1] = 1'b0;
        chk("mid_reset_dut1", W'({busy3, done3, err3, memd3, valm3, st3}), '0);
        wait_done();
        repeat (6) @(posedge clk);
        issue(4'h5, 64'h0, 64'd8, 64'h0, 1'b0); wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parametrised data-memory stage for the SEQ Y86-64 datapath. It sits between execute and write-back. It decodes `icode` to select the access: write `valA`, write `valP`, read via `valE`, read via `valA`, or none. Each access runs through a start/done handshake with a configurable number of wait cycles. Out-of-range accesses are blocked and flagged by a sticky error, and writes to a bad address never reach the memory.

## Interface
Parameters:
- `DATA_W`, default 64: word width of memory, `valA`, `valP`, `valM` and `memdata`.
- `ADDR_W`, default 64: width of the `valA`/`valE` address operands.
- `DEPTH`, default 1024: number of words. Valid addresses are 0..`DEPTH`-1, word-addressed.
- `LAT`, default 1: wait cycles inserted between accept and response, range 0..15.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request strobe. Honoured only when `busy`=0.
- `icode`, in, 4: Y86 instruction code of the request.
- `valA`, in, `ADDR_W`: write data for rmmovq/pushq, and read address for popq/ret.
- `valE`, in, `ADDR_W`: address for rmmovq, mrmovq, pushq and call.
- `valP`, in, `DATA_W`: return address written by call.
- `busy`, out, 1: request in flight. High from the cycle after accept until `done` is seen.
- `done`, out, 1: one-cycle completion pulse.
- `valM`, out, `DATA_W`: read result, valid while `done`=1 and held until the next `done`.
- `memdata`, out, `DATA_W`: word at the last accessed address after the access completes.
- `dmem_err`, out, 1: sticky error. Cleared only by reset.

## Operation
Decode is performed on the operands captured at accept:
- 4 rmmovq: mem[valE] <= valA.
- A pushq: mem[valE] <= valA.
- 8 call: mem[valE] <= valP.
- 5 mrmovq: valM <= mem[valE].
- B popq: valM <= mem[valA].
- 9 ret: valM <= mem[valA].
- Any other icode: no access. `done` pulses one cycle after accept, whatever `LAT` is. `valM`, `memdata` and `dmem_err` are unchanged.

Range check:
- The selected address is in range if it is less than `DEPTH`, compared at full `ADDR_W` width with no truncation.
- Out-of-range write: memory is not modified.
- Out-of-range read: `valM` is 0.
- In both cases `dmem_err` is set at the response edge, `memdata` is 0, and `done` still pulses.

FSM states are IDLE, WAIT and RESP:
- IDLE, `start`=1, memory icode: capture `icode`, the address, write data and the counter, which loads `LAT`. Go to WAIT if `LAT`>0, otherwise RESP.
- IDLE, `start`=1, non-memory icode: go to RESP with no access.
- WAIT: decrement the counter and go to RESP when it reaches 1.
- RESP: `done`=1 for exactly one cycle, then return to IDLE.

Memory effects:
- The write or read is performed on the clock edge that enters RESP.
- `valM` and `memdata` are registered on that same edge.
- For writes, `memdata` equals the written word.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE. `busy`, `done` and `dmem_err` are 0. `valM` and `memdata` are 0. The counter is 0.
- Memory array contents are not reset.
- Reset mid-request aborts it. If the reset edge coincides with the access edge, no write occurs.
- Accept-to-`done` latency is `LAT`+1 cycles for memory icodes and 1 cycle for others.
- `busy`=1 in WAIT and RESP. `start` during `busy` is ignored: no queueing and no error.
- `start` in the same cycle as `done` is ignored. The earliest next accept is the cycle after `done`.
- Input operands are sampled only at accept, so later changes have no effect on the request.
- `dmem_err` is never cleared by a later good access.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, then released. All outputs are 0. `busy`=0 for 5 idle cycles.
- LAT=1 write then read: rmmovq with valE=16, valA=0xDEAD_BEEF gives `done` 2 cycles after accept and memdata=0xDEADBEEF. Then mrmovq with valE=16 gives valM=0xDEADBEEF with `done`, and `dmem_err`=0.
- Stack ops: call with valE=1000, valP=0x40. Then ret with valA=1000 gives valM=0x40. Then pushq with valE=999, valA=7, followed by popq with valA=999, gives valM=7.
- Range error: rmmovq with valE=1024, valA=5 gives `done`, `dmem_err`=1 and memdata=0. A following mrmovq at valE=0 completes normally with `dmem_err` still 1. A probe read of address 0..1023 shows no corruption.
- Busy and non-memory handling, LAT=3:
  - `start` asserted again one cycle after accept is ignored, and only one `done` occurs, 4 cycles after accept.
  - icode=6 (OPq) gives `done` after 1 cycle with valM unchanged.
- Reset mid-request: with LAT=3, rmmovq to valE=8 with valA=9, and `rst_n`=0 on the 2nd WAIT cycle. No `done` is produced, and a later mrmovq at valE=8 returns the prior contents rather than 9.
